usb_tx_bit_encoder: RTL and testbench
=====================================

USB_TX_BIT_ENCODER -- requirements
Module: usb_tx_bit_encoder

Interface
REQ-001 The block SHALL have these ports, in this order:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous, active-low reset.
- tx_start  input  1  one-cycle pulse that begins a packet; honoured only in IDLE.
- tx_data  input  8  payload byte, sent LSB first.
- tx_valid  input  1  tx_data holds a byte.
- tx_last  input  1  qualifies tx_data as the final byte of the packet.
- tx_ready  output  1  one-cycle pulse on the cycle a byte is loaded.
- dp_out  output  1  D+ line level.
- dm_out  output  1  D- line level.
- tx_active  output  1  high from SYNC start to EOP end.
- tx_done  output  1  one-cycle pulse when a packet ends.
- tx_error  output  1  one-cycle pulse on underrun.

REQ-002 Parameter: BIT_PATTERN, no default override; bit periods SHALL be fixed at 8, 8, 9 clocks, repeating.

Function
REQ-003 Bit timing SHALL repeat the period sequence 8, 8, 9 clocks.
- The sequence restarts at the first period on the clock edge that accepts tx_start.
- A bit strobe SHALL assert on the last cycle of each period.
- All line changes SHALL occur on the cycle after a strobe.

REQ-004 FSM states SHALL be IDLE, SYNC, DATA, EOP_SE0A, EOP_SE0B and EOP_J, each lasting whole bit periods.

REQ-005 In IDLE, and on the first cycle after any exit from EOP_J, the line SHALL be J: dp_out=1, dm_out=0.

REQ-006 tx_start in IDLE SHALL move to SYNC and transmit the raw bits 0,0,0,0,0,0,0,1 (LSB-first value 0x80).
- The resulting line sequence is K J K J K J K K.

REQ-007 NRZI encoding SHALL apply to SYNC and DATA bits.
- Raw 0 toggles the line between J and K.
- Raw 1 holds the line.
- K is dp=0, dm=1.

REQ-008 Bit stuffing:
- A ones counter SHALL count consecutive raw 1s, including the final SYNC bit.
- After the sixth consecutive 1, one raw 0 SHALL be inserted before the next payload bit.
- The counter clears on any 0, stuffed or real.
- A stuff bit SHALL delay the shift register by one bit period.

REQ-009 Byte loading:
- On the strobe that ends the last bit of SYNC or of a byte (after any pending stuff bit), if tx_valid=1 the block SHALL load tx_data, pulse tx_ready, capture tx_last, and continue in DATA.
- A stuff bit owed after the last bit of a byte SHALL be sent before the next byte's first bit.

REQ-010 At the end of a byte with captured tx_last=1, the block SHALL send any owed stuff bit, then enter EOP_SE0A.

REQ-011 Underrun: if tx_valid=0 at a load point, the block SHALL pulse tx_error on that strobe cycle and go to EOP_SE0A; no tx_ready pulse occurs.

REQ-012 EOP sequence:
- EOP_SE0A and EOP_SE0B SHALL drive dp=0, dm=0 for one bit each.
- EOP_J SHALL drive J for one bit.
- tx_done SHALL pulse on the final strobe of EOP_J, and the FSM returns to IDLE.

REQ-013 tx_active SHALL be 1 in every state except IDLE.

REQ-014 tx_start while not in IDLE SHALL be ignored.

REQ-015 tx_data, tx_valid and tx_last SHALL be ignored except at load points.

Reset
REQ-016 Asynchronous reset, including mid-packet, SHALL immediately force:
- IDLE state;
- dp_out=1, dm_out=0;
- tx_active=0, tx_ready=0, tx_done=0, tx_error=0;
- cleared timer, ones counter, shift register and bit index.

REQ-017 The first tx_start after reset release SHALL begin a normal SYNC.

Structure
REQ-018 A shared package usb_tx_pkg SHALL hold:
- the FSM state enum;
- SYNC_BYTE=8'h80;
- STUFF_LIMIT=6;
- line-level constants for J, K and SE0.

REQ-019 Bit timing SHALL be a sub-module bit_pd_timer_tx.
- Inputs: enable, restart.
- Output: strobe.
- It implements the 8/8/9 sequence.
- All encoding, stuffing and FSM logic SHALL stay in usb_tx_bit_encoder.

Verification
REQ-020 Reset idle: hold n_rst=0, release, wait 100 clocks -> dp_out=1, dm_out=0, all pulses 0, tx_active=0.

REQ-021 Single byte: tx_start, then tx_data=8'h00 with tx_valid=1 and tx_last=1 -> line sequence:
- K J K J K J K K for SYNC;
- J K J K J K J K for the byte;
- SE0, SE0, J for EOP.
- The bench checks the 8/8/9 period spacing, one tx_ready pulse at the SYNC end, and tx_done on the last EOP strobe.

REQ-022 Stuffing: byte 8'hFF with tx_last=1 -> exactly one stuff bit (a toggle) inserted after the fifth data bit, since the final SYNC 1 counts toward the six; the total packet takes 8+9+3 = 20 bit periods.

REQ-023 Multi-byte: bytes 8'h3C then 8'hC3 (the second with tx_last) -> two tx_ready pulses spaced exactly 8 bit periods apart, with the correct NRZI stream.

REQ-024 Underrun: tx_start with tx_valid=0 -> tx_error pulse at the end of SYNC, then SE0, SE0, J, tx_done, and no tx_ready.

REQ-025 Mid-packet reset: assert n_rst during the third data bit -> line is J immediately; a new packet sent afterwards is bit-exact.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit bit encoder.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_DATA     = 3'd2,
    ST_EOP_SE0A = 3'd3,
    ST_EOP_SE0B = 3'd4,
    ST_EOP_J    = 3'd5
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // Line levels packed as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // Bit period lengths in clocks: two short periods then one long one
  localparam logic [3:0] PERIOD_SHORT = 4'd8;
  localparam logic [3:0] PERIOD_LONG  = 4'd9;

  // NRZI: a raw 0 flips between J and K, a raw 1 holds the line
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic raw);
    if (raw) return line;
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/bit_pd_timer_tx.sv
// Bit period timer: strobes on the last clock of each 8, 8, 9 clock period.
module bit_pd_timer_tx
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_strobe
);

  logic [3:0] r_cnt;
  logic [1:0] r_phase;
  logic [3:0] w_last_cnt;

  assign w_last_cnt = (r_phase == 2'd2) ? (PERIOD_LONG - 4'd1) : (PERIOD_SHORT - 4'd1);
  assign o_strobe   = i_enable && (r_cnt == w_last_cnt);

  // Count clocks within the period and step the 8/8/9 phase on each strobe
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt   <= 4'd0;
      r_phase <= 2'd0;
    end else if (i_restart || !i_enable) begin
      r_cnt   <= 4'd0;
      r_phase <= 2'd0;
    end else if (o_strobe) begin
      r_cnt   <= 4'd0;
      r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
    end else begin
      r_cnt   <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/usb_tx_bit_encoder.sv
// USB low-level transmitter: SYNC, NRZI payload with bit stuffing, EOP.
// Byte handshake: tx_valid/tx_data/tx_last are sampled only on the strobe
// that ends SYNC or a byte (after any owed stuff bit); tx_ready pulses on
// that same cycle when tx_valid is high, otherwise tx_error pulses.
module usb_tx_bit_encoder
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_error
);

  tx_state_e  r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;      // bit on the line is r_shift[0]
  logic [2:0] r_bit_idx, w_bit_idx_nxt;  // payload bit index within SYNC/byte
  logic [2:0] r_ones, w_ones_nxt;        // consecutive raw 1s sent
  logic       r_stuff, w_stuff_nxt;      // current bit is an inserted stuff 0
  logic       r_pend_load, w_pend_load_nxt; // stuff bit closes a byte
  logic       r_last, w_last_nxt;
  logic [1:0] r_line, w_line_nxt;

  logic       w_strobe;
  logic       w_cur_bit;
  logic [2:0] w_ones_upd;
  logic [7:0] w_shift_adv;
  logic [2:0] w_idx_adv;
  logic       w_byte_end;

  bit_pd_timer_tx u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_enable  (r_state != ST_IDLE),
    .i_restart ((r_state == ST_IDLE) && tx_start),
    .o_strobe  (w_strobe)
  );

  // A stuff bit holds the shift register and bit index for one period
  assign w_cur_bit   = r_stuff ? 1'b0 : r_shift[0];
  assign w_ones_upd  = w_cur_bit ? (r_ones + 3'd1) : 3'd0;
  assign w_shift_adv = r_stuff ? r_shift : {1'b0, r_shift[7:1]};
  assign w_idx_adv   = r_stuff ? r_bit_idx : (r_bit_idx + 3'd1);
  assign w_byte_end  = r_stuff ? r_pend_load : (r_bit_idx == 3'd7);

  assign dp_out    = r_line[1];
  assign dm_out    = r_line[0];
  assign tx_active = (r_state != ST_IDLE);

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= 8'd0;
      r_bit_idx   <= 3'd0;
      r_ones      <= 3'd0;
      r_stuff     <= 1'b0;
      r_pend_load <= 1'b0;
      r_last      <= 1'b0;
      r_line      <= LINE_J;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_ones      <= w_ones_nxt;
      r_stuff     <= w_stuff_nxt;
      r_pend_load <= w_pend_load_nxt;
      r_last      <= w_last_nxt;
      r_line      <= w_line_nxt;
    end
  end

  // Next-state, next line level and handshake pulses
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_bit_idx_nxt   = r_bit_idx;
    w_ones_nxt      = r_ones;
    w_stuff_nxt     = r_stuff;
    w_pend_load_nxt = r_pend_load;
    w_last_nxt      = r_last;
    w_line_nxt      = r_line;
    tx_ready        = 1'b0;
    tx_error        = 1'b0;
    tx_done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_line_nxt = LINE_J;
        if (tx_start) begin
          w_state_nxt     = ST_SYNC;
          w_shift_nxt     = SYNC_BYTE;
          w_bit_idx_nxt   = 3'd0;
          w_ones_nxt      = 3'd0;
          w_stuff_nxt     = 1'b0;
          w_pend_load_nxt = 1'b0;
          w_last_nxt      = 1'b0;
          w_line_nxt      = nrzi_next(LINE_J, SYNC_BYTE[0]);
        end
      end
      ST_SYNC, ST_DATA: begin
        if (w_strobe) begin
          w_ones_nxt      = w_ones_upd;
          w_shift_nxt     = w_shift_adv;
          w_bit_idx_nxt   = w_idx_adv;
          w_stuff_nxt     = 1'b0;
          w_pend_load_nxt = 1'b0;
          if (w_ones_upd == STUFF_LIMIT) begin
            w_stuff_nxt     = 1'b1;
            w_pend_load_nxt = (r_bit_idx == 3'd7);
            w_line_nxt      = nrzi_next(r_line, 1'b0);
          end else if (w_byte_end) begin
            if (r_last) begin
              w_state_nxt = ST_EOP_SE0A;
              w_line_nxt  = LINE_SE0;
            end else if (tx_valid) begin
              tx_ready      = 1'b1;
              w_state_nxt   = ST_DATA;
              w_shift_nxt   = tx_data;
              w_bit_idx_nxt = 3'd0;
              w_last_nxt    = tx_last;
              w_line_nxt    = nrzi_next(r_line, tx_data[0]);
            end else begin
              tx_error    = 1'b1;
              w_state_nxt = ST_EOP_SE0A;
              w_line_nxt  = LINE_SE0;
            end
          end else begin
            w_line_nxt = nrzi_next(r_line, w_shift_adv[0]);
          end
        end
      end
      ST_EOP_SE0A: begin
        if (w_strobe) w_state_nxt = ST_EOP_SE0B;
      end
      ST_EOP_SE0B: begin
        if (w_strobe) begin
          w_state_nxt = ST_EOP_J;
          w_line_nxt  = LINE_J;
        end
      end
      ST_EOP_J: begin
        if (w_strobe) begin
          tx_done     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_line_nxt  = LINE_J;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_line_nxt  = LINE_J;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_bit_encoder.sv
// Bench for usb_tx_bit_encoder: per-cycle line/pulse checks against a
// bit-stream model built from SYNC, stuffing and NRZI rules.
module tb_usb_tx_bit_encoder;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  // Clock / reset / DUT
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, dp_out, dm_out, tx_active, tx_done, tx_error;

  always #5 clk = ~clk;

  usb_tx_bit_encoder dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .dp_out    (dp_out),
    .dm_out    (dm_out),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected line level for each bit period of a packet
  logic [1:0] exp_q[$];
  int         load_bit[$];   // bit index whose strobe is a load point
  bit         load_ok[$];    // tx_valid presented at that load point
  logic [7:0] pkt_q[$];      // payload bytes
  bit         under;         // after pkt_q, present tx_valid=0 instead of ending
  logic [1:0] m_line;
  int         m_ones;

  task automatic m_push(input bit raw);
    if (!raw) m_line = (m_line == J) ? K : J;
    exp_q.push_back(m_line);
    m_ones = raw ? m_ones + 1 : 0;
  endtask

  task automatic m_push_payload(input bit raw);
    m_push(raw);
    if (m_ones == 6) m_push(1'b0);
  endtask

  task automatic build_model();
    logic [7:0] s;
    logic [7:0] b;
    exp_q.delete();
    load_bit.delete();
    load_ok.delete();
    m_line = J;
    m_ones = 0;
    s = 8'h80;
    for (int i = 0; i < 8; i++) m_push_payload(s[i]);
    for (int j = 0; j <= pkt_q.size(); j++) begin
      if (j == pkt_q.size()) begin
        if (under) begin
          load_bit.push_back(exp_q.size() - 1);
          load_ok.push_back(1'b0);
        end
        break;
      end
      load_bit.push_back(exp_q.size() - 1);
      load_ok.push_back(1'b1);
      b = pkt_q[j];
      for (int i = 0; i < 8; i++) m_push_payload(b[i]);
    end
    exp_q.push_back(SE0);
    exp_q.push_back(SE0);
    exp_q.push_back(J);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_line"}, {dp_out, dm_out}, J);
    check_val({tag, "_active"}, tx_active, 1'b0);
    check_val({tag, "_pulses"}, {tx_ready, tx_error, tx_done}, 3'b000);
  endtask

  // Driver + per-cycle compare; abort_bit >= 0 resets mid-way through that bit
  task automatic run_packet(input int abort_bit);
    int k, pos, plen, ld;
    bit strobe, is_load;
    logic [2:0] exp_p;
    build_model();
    @(negedge clk);
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    k = 0; pos = 0; ld = 0;
    while (k < exp_q.size()) begin
      plen    = (k % 3 == 2) ? 9 : 8;
      strobe  = (pos == plen - 1);
      is_load = strobe && (ld < load_bit.size()) && (load_bit[ld] == k);
      if (is_load) begin
        tx_valid = load_ok[ld];
        tx_data  = load_ok[ld] ? pkt_q[ld] : 8'($urandom);
        tx_last  = load_ok[ld] && !under && (ld == pkt_q.size() - 1);
      end else begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom_range(0, 1));
      end
      tx_start = 1'($urandom_range(0, 1));
      if (k == abort_bit && pos == 3) begin
        #2 n_rst = 1'b0;
        #1 check_idle("async_rst");
        tx_start = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check_idle("in_rst");
        n_rst = 1'b1;
        return;
      end
      exp_p = 3'b000;
      if (is_load) exp_p = load_ok[ld] ? 3'b100 : 3'b010;
      if (strobe && k == exp_q.size() - 1) exp_p[0] = 1'b1;
      @(negedge clk);
      check_val("line", {dp_out, dm_out}, exp_q[k]);
      check_val("active", tx_active, 1'b1);
      check_val("pulses", {tx_ready, tx_error, tx_done}, exp_p);
      if (is_load) ld++;
      @(posedge clk);
      #1;
      pos++;
      if (strobe) begin
        pos = 0;
        k++;
      end
    end
    tx_start = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check_idle("post_pkt");
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      tx_data  = 8'($urandom);
      tx_valid = 1'($urandom_range(0, 1));
      tx_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle("gap");
    end
  endtask

  // Main sequence and final report
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("rst_hold");
    n_rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check_idle("rst_idle");

    under = 1'b0; pkt_q = '{8'h00};         run_packet(-1); idle_gap();
    under = 1'b0; pkt_q = '{8'hFF};         run_packet(-1); idle_gap();
    under = 1'b0; pkt_q = '{8'h3C, 8'hC3};  run_packet(-1); idle_gap();
    under = 1'b1; pkt_q.delete();           run_packet(-1); idle_gap();
    under = 1'b0; pkt_q = '{8'hA5, 8'h5A};  run_packet(10); idle_gap();
    under = 1'b0; pkt_q = '{8'h7E, 8'hFF, 8'h01}; run_packet(-1); idle_gap();

    for (int p = 0; p < 24; p++) begin
      under = ($urandom_range(0, 3) == 0);
      n = under ? $urandom_range(0, 3) : $urandom_range(1, 4);
      pkt_q.delete();
      for (int i = 0; i < n; i++)
        pkt_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_packet(-1);
      idle_gap();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
